// File: rtl/rotation_point_transform_pkg.sv
// Shared types and width/bound helpers for the rotation point transform.
package rotation_point_transform_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDone
  } state_e;

  localparam int unsigned NumSteps = 9;

  function automatic int unsigned prod_width(int unsigned decimal_bits, int unsigned coord_bits);
    return coord_bits + decimal_bits + 2;
  endfunction

  // Two guard bits above the product hold the three-term row sum without overflow.
  function automatic int unsigned acc_width(int unsigned decimal_bits, int unsigned coord_bits);
    return coord_bits + decimal_bits + 4;
  endfunction

  function automatic longint sat_max(int unsigned coord_bits);
    return (longint'(1) << (coord_bits - 1)) - 1;
  endfunction

  function automatic longint sat_min(int unsigned coord_bits);
    return -(longint'(1) << (coord_bits - 1));
  endfunction

endpackage

// File: rtl/rotation_point_transform_if.sv
// Matrix-load, point-in and point-out bundle of the rotation point transform.
interface rotation_point_transform_if #(
  parameter int unsigned decimalBits = 8,
  parameter int unsigned coordBits   = 16
);

  logic signed [decimalBits+1:0] m_00, m_01, m_02;
  logic signed [decimalBits+1:0] m_10, m_11, m_12;
  logic signed [decimalBits+1:0] m_20, m_21, m_22;
  logic                          matrixEnable;

  logic signed [coordBits-1:0]   p_x, p_y, p_z;
  logic                          pointValid;
  logic                          pointReady;

  logic signed [coordBits-1:0]   q_x, q_y, q_z;
  logic                          outputEnable;

  modport master (
    output m_00, m_01, m_02, m_10, m_11, m_12, m_20, m_21, m_22, matrixEnable,
    output p_x, p_y, p_z, pointValid,
    input  pointReady, q_x, q_y, q_z, outputEnable
  );

  modport slave (
    input  m_00, m_01, m_02, m_10, m_11, m_12, m_20, m_21, m_22, matrixEnable,
    input  p_x, p_y, p_z, pointValid,
    output pointReady, q_x, q_y, q_z, outputEnable
  );

endinterface

// File: rtl/rotation_point_transform_mult.sv
// Combinational radix-2 Booth signed multiplier, full-precision product.
module rotation_point_transform_mult #(
  parameter int unsigned AWidth = 16,
  parameter int unsigned BWidth = 10
) (
  input  logic signed [AWidth-1:0]        i_a,
  input  logic signed [BWidth-1:0]        i_b,
  output logic signed [AWidth+BWidth-1:0] o_p
);

  localparam int unsigned PWidth = AWidth + BWidth;

  logic signed [PWidth-1:0] w_a_ext;
  logic        [BWidth:0]   w_b_pad;

  assign w_a_ext = {{BWidth{i_a[AWidth-1]}}, i_a};
  assign w_b_pad = {i_b, 1'b0};

  // The top recoded pair carries the sign of i_b, so no correction term is needed.
  always_comb begin
    o_p = '0;
    for (int i = 0; i < int'(BWidth); i++) begin
      case (w_b_pad[i+1 -: 2])
        2'b01:   o_p = o_p + (w_a_ext <<< i);
        2'b10:   o_p = o_p - (w_a_ext <<< i);
        default: o_p = o_p;
      endcase
    end
  end

endmodule

// File: rtl/rotation_point_transform.sv
// Rotates integer 3D points by a latched Q1.decimalBits matrix, one shared multiplier over
// nine steps; a new matrix may arrive at any time and applies from the next accepted point.
module rotation_point_transform
  import rotation_point_transform_pkg::*;
#(
  parameter int unsigned decimalBits = 8,
  parameter int unsigned coordBits   = 16
) (
  input logic                         clk,
  input logic                         reset,
  rotation_point_transform_if.slave   bus
);

  localparam int unsigned MW = decimalBits + 2;
  localparam int unsigned PW = prod_width(decimalBits, coordBits);
  localparam int unsigned AW = acc_width(decimalBits, coordBits);
  localparam logic [3:0]  LastStep = 4'(NumSteps - 1);
  localparam logic signed [AW-1:0] SatMax = AW'(sat_max(coordBits));
  localparam logic signed [AW-1:0] SatMin = AW'(sat_min(coordBits));

  state_e                      r_state, w_state_next;
  logic [3:0]                  r_step;
  logic                        r_loaded;
  logic signed [MW-1:0]        r_held [9];
  logic signed [MW-1:0]        r_work [9];
  logic signed [coordBits-1:0] r_p    [3];
  logic signed [coordBits-1:0] r_res  [3];
  logic signed [coordBits-1:0] r_q    [3];
  logic signed [AW-1:0]        r_acc;
  logic                        r_oe;

  logic signed [MW-1:0]        w_m_in [9];
  logic                        w_ready, w_accept;
  logic [1:0]                  w_row, w_col;
  logic signed [coordBits-1:0] w_mul_a;
  logic signed [MW-1:0]        w_mul_b;
  logic signed [PW-1:0]        w_prod;
  logic signed [AW-1:0]        w_prod_ext, w_sum, w_shift;
  logic signed [coordBits-1:0] w_sat;

  assign w_m_in[0] = bus.m_00;
  assign w_m_in[1] = bus.m_01;
  assign w_m_in[2] = bus.m_02;
  assign w_m_in[3] = bus.m_10;
  assign w_m_in[4] = bus.m_11;
  assign w_m_in[5] = bus.m_12;
  assign w_m_in[6] = bus.m_20;
  assign w_m_in[7] = bus.m_21;
  assign w_m_in[8] = bus.m_22;

  assign w_ready  = (r_state == StIdle) && r_loaded;
  assign w_accept = bus.pointValid && w_ready;

  assign w_row = 2'(r_step / 4'd3);
  assign w_col = 2'(r_step % 4'd3);

  always_comb begin
    w_mul_a = r_p[0];
    case (w_col)
      2'd1:    w_mul_a = r_p[1];
      2'd2:    w_mul_a = r_p[2];
      default: w_mul_a = r_p[0];
    endcase
  end

  // Row-major step index addresses the working bank directly.
  assign w_mul_b = r_work[r_step];

  rotation_point_transform_mult #(
    .AWidth(coordBits),
    .BWidth(MW)
  ) u_mult (
    .i_a(w_mul_a),
    .i_b(w_mul_b),
    .o_p(w_prod)
  );

  assign w_prod_ext = {{(AW - PW){w_prod[PW-1]}}, w_prod};
  assign w_sum      = (w_col == 2'd0) ? w_prod_ext : r_acc + w_prod_ext;
  assign w_shift    = w_sum >>> decimalBits;

  always_comb begin
    w_sat = w_shift[coordBits-1:0];
    if (w_shift > SatMax) begin
      w_sat = {1'b0, {(coordBits - 1){1'b1}}};
    end else if (w_shift < SatMin) begin
      w_sat = {1'b1, {(coordBits - 1){1'b0}}};
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StMul;
      StMul:   if (r_step == LastStep) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_step   <= '0;
      r_loaded <= 1'b0;
      r_held   <= '{default: '0};
      r_work   <= '{default: '0};
      r_p      <= '{default: '0};
      r_res    <= '{default: '0};
      r_q      <= '{default: '0};
      r_acc    <= '0;
      r_oe     <= 1'b0;
    end else begin
      r_oe <= (r_state == StDone);
      if (bus.matrixEnable) begin
        r_held   <= w_m_in;
        r_loaded <= 1'b1;
      end
      // Nonblocking read of r_held gives the pre-update matrix on a simultaneous load.
      if (w_accept) begin
        r_work <= r_held;
        r_p[0] <= bus.p_x;
        r_p[1] <= bus.p_y;
        r_p[2] <= bus.p_z;
        r_step <= '0;
      end
      if (r_state == StMul) begin
        r_step <= r_step + 4'd1;
        r_acc  <= w_sum;
        if (w_col == 2'd2) begin
          r_res[w_row] <= w_sat;
        end
      end
      if (r_state == StDone) begin
        r_q <= r_res;
      end
    end
  end

  assign bus.pointReady   = w_ready;
  assign bus.outputEnable = r_oe;
  assign bus.q_x          = r_q[0];
  assign bus.q_y          = r_q[1];
  assign bus.q_z          = r_q[2];

endmodule
